// File: rtl/prim_pad_attr_sequencer.sv
// Pad attribute sequencer: holds live per-pad attributes and applies software
// updates one at a time, holding the target pad's output enable off around each change.

package prim_pad_attr_sequencer_pkg;

  // Per-pad attribute word; invert is the LSB.
  typedef struct packed {
    logic slew_rate;
    logic od_en;
    logic schmitt_en;
    logic keeper_en;
    logic pull_select;
    logic pull_en;
    logic virt_od_en;
    logic invert;
  } pad_attr_t;

endpackage

module prim_pad_attr_sequencer
  import prim_pad_attr_sequencer_pkg::*;
#(
  parameter int unsigned NumPads      = 8,
  parameter int unsigned SettleCycles = 4,
  localparam int unsigned IdxW        = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        req_i,
  input  logic [IdxW-1:0]             pad_idx_i,
  input  pad_attr_t                   attr_i,
  output logic                        ack_o,
  output logic                        err_o,
  output logic                        busy_o,
  input  logic [NumPads-1:0]          oe_i,
  output logic [NumPads-1:0]          oe_o,
  output pad_attr_t [NumPads-1:0]     attr_o
);

  localparam int unsigned CntW = $clog2(SettleCycles + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(SettleCycles - 1);

  if (SettleCycles < 1) begin : g_bad_settle
    $error("SettleCycles must be at least 1");
  end
  if (NumPads < 1) begin : g_bad_pads
    $error("NumPads must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_APPLY,
    ST_RESUME,
    ST_ACK
  } state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [IdxW-1:0]           idx_q, idx_d;
  pad_attr_t                 cap_q, cap_d;
  pad_attr_t [NumPads-1:0]   pads_q, pads_d;
  logic [NumPads-1:0]        force_q, force_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic                      busy_q, busy_d;

  // Next-state and datapath: capture on acceptance, settle, apply, settle, acknowledge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    pads_d  = pads_q;
    force_d = force_q;
    ack_d   = ack_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          idx_d = pad_idx_i;
          cap_d = attr_i;
          if (32'(pad_idx_i) >= NumPads) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (attr_i == pads_q[pad_idx_i]) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            err_d   = 1'b0;
          end else begin
            state_d            = ST_QUIESCE;
            force_d            = '0;
            force_d[pad_idx_i] = 1'b1;
            cnt_d              = CntLoad;
          end
        end
      end
      ST_QUIESCE: begin
        if (cnt_q == '0) begin
          state_d = ST_APPLY;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_APPLY: begin
        pads_d[idx_q] = cap_q;
        cnt_d         = CntLoad;
        state_d       = ST_RESUME;
      end
      ST_RESUME: begin
        if (cnt_q == '0) begin
          force_d = '0;
          state_d = ST_ACK;
          ack_d   = 1'b1;
          err_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_ACK: begin
        if (!req_i) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        force_d = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and attribute registers; reset drops all forces and zeroes every pad.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      pads_q  <= '0;
      force_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      pads_q  <= pads_d;
      force_q <= force_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign oe_o   = oe_i & ~force_q;
  assign attr_o = pads_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_prim_pad_attr_sequencer.sv
// Bench for prim_pad_attr_sequencer: a request-level timeline model checked every
// cycle, plus literal expectations for the key scenarios.
// Six pads are used so a 3-bit index can address a non-existent pad (6 and 7).

module tb_prim_pad_attr_sequencer;
  import prim_pad_attr_sequencer_pkg::*;

  localparam int unsigned N    = 6;
  localparam int unsigned S    = 4;
  localparam int unsigned IdxW = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req;
  logic [IdxW-1:0]      pad_idx;
  pad_attr_t            attr;
  logic                 ack, err, busy;
  logic [N-1:0]         oe_in, oe_out;
  pad_attr_t [N-1:0]    attr_out;

  int checks = 0;
  int errors = 0;

  prim_pad_attr_sequencer #(.NumPads(N), .SettleCycles(S)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .pad_idx_i(pad_idx),
    .attr_i   (attr),
    .ack_o    (ack),
    .err_o    (err),
    .busy_o   (busy),
    .oe_i     (oe_in),
    .oe_o     (oe_out),
    .attr_o   (attr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a request is a timeline counted from its acceptance edge.
  typedef enum int {M_IDLE, M_RUN, M_ACK} mmode_e;
  mmode_e    m_mode = M_IDLE;
  int        m_d    = 0;
  int        m_idx  = 0;
  logic [7:0] m_attr = '0;
  logic      m_err  = 1'b0;
  logic [7:0] exp_attr [N];

  function automatic logic [8*N-1:0] packed_exp();
    logic [8*N-1:0] v;
    for (int i = 0; i < N; i++) v[8*i +: 8] = exp_attr[i];
    return v;
  endfunction

  // Model advance at each edge, then compare a little after it.
  initial begin
    for (int i = 0; i < N; i++) exp_attr[i] = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = M_IDLE;
        m_err  = 1'b0;
        for (int i = 0; i < N; i++) exp_attr[i] = '0;
      end else begin
        case (m_mode)
          M_IDLE: if (req) begin
            m_idx  = int'(pad_idx);
            m_attr = attr;
            if (m_idx >= int'(N)) begin
              m_mode = M_ACK; m_err = 1'b1;
            end else if (attr == exp_attr[m_idx]) begin
              m_mode = M_ACK; m_err = 1'b0;
            end else begin
              m_mode = M_RUN; m_d = 1;
            end
          end
          M_RUN: begin
            m_d++;
            if (m_d == int'(S) + 2) exp_attr[m_idx] = m_attr;
            if (m_d == 2 * int'(S) + 2) begin
              m_mode = M_ACK; m_err = 1'b0;
            end
          end
          default: if (!req) m_mode = M_IDLE;
        endcase
      end
      #1;
      begin
        logic [N-1:0] fmask;
        fmask = (m_mode == M_RUN) ? N'(1) << m_idx : '0;
        chk("model_oe",   64'(oe_out), 64'(oe_in & ~fmask));
        chk("model_attr", 64'(attr_out), 64'(packed_exp()));
        chk("model_ack",  64'(ack),  64'(m_mode == M_ACK));
        chk("model_err",  64'(err),  64'(m_mode == M_ACK && m_err));
        chk("model_busy", 64'(busy), 64'(m_mode != M_IDLE));
      end
    end
  end

  task automatic drop_req();
    @(negedge clk);
    req = 1'b0;
    @(posedge clk); #1;
    chk("drop_ack",  64'(ack),  64'(0));
    chk("drop_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; pad_idx = '0; attr = '0; oe_in = 6'h3F;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    @(posedge clk); #1;
    chk("rst_attr", 64'(attr_out), 64'(0));
    chk("rst_oe",   64'(oe_out),   64'(6'h3F));
    chk("rst_ack",  64'(ack),      64'(0));
    chk("rst_busy", 64'(busy),     64'(0));

    // Full update of pad 3 (invert), req held 5 cycles past ack; inputs scrambled after acceptance.
    @(negedge clk);
    req = 1'b1; pad_idx = 3'd3; attr = 8'h01;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      chk("upd_oe",     64'(oe_out), 64'((i <= 9) ? 6'h37 : 6'h3F));
      chk("upd_invert", 64'(attr_out[3].invert), 64'(i >= 6));
      chk("upd_ack",    64'(ack), 64'(i >= 10));
      chk("upd_busy",   64'(busy), 64'(1));
      if (i == 2) begin
        @(negedge clk);
        pad_idx = 3'd1; attr = 8'hA5;
      end
    end
    drop_req();

    // Out-of-range pad: immediate error ack, nothing changes.
    @(negedge clk);
    req = 1'b1; pad_idx = 3'd7; attr = 8'hFF;
    @(posedge clk); #1;
    chk("err_ack", 64'(ack), 64'(1));
    chk("err_err", 64'(err), 64'(1));
    chk("err_oe",  64'(oe_out), 64'(6'h3F));
    chk("err_attr3", 64'(attr_out[3]), 64'(8'h01));
    drop_req();

    // Same attributes as live: no-op ack, no gating.
    @(negedge clk);
    req = 1'b1; pad_idx = 3'd3; attr = 8'h01;
    @(posedge clk); #1;
    chk("noop_ack", 64'(ack), 64'(1));
    chk("noop_err", 64'(err), 64'(0));
    chk("noop_oe",  64'(oe_out), 64'(6'h3F));
    drop_req();

    // Pad 0 update with oe_i toggling every cycle; the model checks the gating.
    @(negedge clk);
    req = 1'b1; pad_idx = 3'd0; attr = 8'h80;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      oe_in = N'($urandom);
    end
    chk("tog_ack", 64'(ack), 64'(1));
    drop_req();
    oe_in = 6'h3F;

    // Reset during cycle 7 of a pad-2 update.
    @(negedge clk);
    req = 1'b1; pad_idx = 3'd2; attr = 8'h03;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_attr2_applied", 64'(attr_out[2]), 64'(8'h03));
    chk("mid_oe_forced",     64'(oe_out), 64'(6'h3B));
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_oe",    64'(oe_out), 64'(oe_in));
    chk("rst_mid_attr2", 64'(attr_out[2]), 64'(0));
    chk("rst_mid_attr3", 64'(attr_out[3]), 64'(0));
    chk("rst_mid_ack",   64'(ack),  64'(0));
    chk("rst_mid_busy",  64'(busy), 64'(0));
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Normal operation resumes after reset.
    @(negedge clk);
    req = 1'b1; pad_idx = 3'd5; attr = 8'h10;
    for (int i = 1; i <= 2 * int'(S) + 2; i++) begin
      @(posedge clk); #1;
    end
    chk("post_ack",   64'(ack), 64'(1));
    chk("post_attr5", 64'(attr_out[5]), 64'(8'h10));
    drop_req();

    repeat (2) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
